// File: rtl/jk_bank_ctrl_if.sv
// Command handshake and JK bank connection bundle for jk_bank_ctrl.
// The master side is the host plus the flip-flop bank; the slave side is the controller.
interface jk_bank_ctrl_if #(
   parameter int N  = 4,
   parameter int CW = 8
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [N-1:0]  cmd_arg;
   logic [CW-1:0] cmd_steps;
   logic [N-1:0]  q;
   logic [N-1:0]  j;
   logic [N-1:0]  k;
   logic          busy;
   logic          done;
   logic [CW-1:0] steps_left;

   modport master (
      output cmd_valid, cmd_op, cmd_arg, cmd_steps, q,
      input  cmd_ready, j, k, busy, done, steps_left
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_arg, cmd_steps, q,
      output cmd_ready, j, k, busy, done, steps_left
   );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Sequencer that drives a bank of JK flip-flops for a programmed number of edges.
// Supports load, set, clear, masked toggle and synchronous up/down counting.
module jk_bank_ctrl #(
   parameter int N  = 4,
   parameter int CW = 8
) (
   input logic           clk,
   input logic           rst,
   jk_bank_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic [2:0]    r_op;
   logic [N-1:0]  r_arg;
   logic [CW-1:0] r_stepsLeft;
   logic          w_accept;
   logic [CW-1:0] w_effSteps;
   logic [N-1:0]  w_upEn;
   logic [N-1:0]  w_dnEn;
   logic [N-1:0]  w_j;
   logic [N-1:0]  w_k;
   logic          w_ready;
   logic          w_done;

   assign w_accept = (r_state == IDLE) && bus.cmd_valid;

   // Only the toggle/count ops repeat; a zero step count still runs one edge.
   always_comb begin
      w_effSteps = CW'(1);
      if ((bus.cmd_op == 3'd3 || bus.cmd_op == 3'd4 || bus.cmd_op == 3'd5) &&
          (bus.cmd_steps != '0)) begin
         w_effSteps = bus.cmd_steps;
      end
   end

   // Ripple-style synchronous counter enables taken straight from live q.
   assign w_upEn[0] = 1'b1;
   assign w_dnEn[0] = 1'b1;
   for (genvar gi = 1; gi < N; gi++) begin : g_cnt
      assign w_upEn[gi] = &bus.q[gi-1:0];
      assign w_dnEn[gi] = ~|bus.q[gi-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_op        <= '0;
         r_arg       <= '0;
         r_stepsLeft <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_op        <= bus.cmd_op;
            r_arg       <= bus.cmd_arg;
            r_stepsLeft <= w_effSteps;
         end else if (r_state == RUN) begin
            r_stepsLeft <= r_stepsLeft - CW'(1);
         end
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_ready     = 1'b0;
      w_done      = 1'b0;
      w_j         = '0;
      w_k         = '0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (w_accept) begin
               w_nextState = RUN;
            end
         end
         RUN: begin
            if (r_stepsLeft == CW'(1)) begin
               w_nextState = DONE;
            end
            case (r_op)
               3'd1: begin
                  w_j = r_arg;
                  w_k = ~r_arg;
               end
               3'd2: w_k = '1;
               3'd3: begin
                  w_j = r_arg;
                  w_k = r_arg;
               end
               3'd4: begin
                  w_j = w_upEn;
                  w_k = w_upEn;
               end
               3'd5: begin
                  w_j = w_dnEn;
                  w_k = w_dnEn;
               end
               3'd6: w_j = '1;
               default: begin
                  w_j = '0;
                  w_k = '0;
               end
            endcase
         end
         DONE: begin
            w_done      = 1'b1;
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   assign bus.cmd_ready  = w_ready;
   assign bus.done       = w_done;
   assign bus.busy       = (r_state != IDLE);
   assign bus.j          = w_j;
   assign bus.k          = w_k;
   assign bus.steps_left = r_stepsLeft;

endmodule
